fetch_pc_unit: RTL and testbench

Owns the architectural fetch PC and drives instruction-memory requests. It consumes the redirect pair produced by the next-PC logic (target word address plus take-redirect flag) and hands fetched instructions, tagged with their PC, to decode over a valid/ready interface. Fetches are word-addressed: the PC is 30 bits and the byte address is {pc, 2'b00}. It holds at most one outstanding memory request and uses a small instruction buffer to absorb decode back-pressure.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/inst_fifo.sv | 49 ++++
 rtl/fetch_pc_unit.sv | 86 ++++++++
 tb/tb_fetch_pc_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-side types: datapath widths, fetch FSM encoding, buffer entry
// layout and the word-to-byte address helper.
package cpu_pkg;

    localparam int PC_W   = 30;
    localparam int INST_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] byte_addr(input logic [PC_W-1:0] pc);
        return {pc, 2'b00};
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Instruction buffer between fetch and decode: a small ring of {pc, inst}
// entries with a flush that wins over push and pop.
module inst_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [PC_W-1:0]              wr_pc,
    input  logic [INST_W-1:0]            wr_inst,
    output logic [PC_W-1:0]              rd_pc,
    output logic [INST_W-1:0]            rd_inst,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    assign rd_pc   = mem[rd_ptr].pc;
    assign rd_inst = mem[rd_ptr].inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: wr_pc, inst: wr_inst};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: issues one outstanding instruction-memory request at a time,
// follows redirects (dropping stale data) and buffers fetched words for decode.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_PCSrc,
    input  logic [PC_W-1:0]   i_PC_target,
    output logic              o_imem_req,
    output logic [31:0]       o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [INST_W-1:0] i_imem_data,
    output logic              o_inst_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [PC_W-1:0]   o_inst_pc,
    input  logic              i_inst_ready
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e    state, state_next;
    logic [PC_W-1:0] fetch_pc, pc_next;
    logic [CW-1:0]   count, count_next;
    logic            ack, push, pop, space, addr_load;

    // An ack only means something while a request is outstanding.
    assign ack   = i_imem_ack & (state != IDLE);
    assign push  = ack & (state == WAIT) & ~i_PCSrc;
    assign pop   = o_inst_valid & i_inst_ready;
    assign o_inst_valid = (count != '0);

    assign count_next = i_PCSrc ? '0 : count + CW'(push) - CW'(pop);
    assign space      = count_next < CW'(BUF_DEPTH);

    assign pc_next = i_PCSrc ? i_PC_target :
                     push    ? fetch_pc + 1'b1 : fetch_pc;

    // The bus address must not move under an unacknowledged request, so it
    // only reloads when nothing is outstanding or the request just completed.
    assign addr_load = (state == IDLE) | ack;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: state_next = space ? WAIT : IDLE;
            WAIT,
            DROP: begin
                if (ack)          state_next = space ? WAIT : IDLE;
                else if (i_PCSrc) state_next = DROP;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            o_imem_req  <= 1'b0;
            o_imem_addr <= byte_addr(RESET_PC);
        end else begin
            state      <= state_next;
            fetch_pc   <= pc_next;
            o_imem_req <= (state_next != IDLE);
            if (addr_load) o_imem_addr <= byte_addr(pc_next);
        end
    end

    inst_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (i_PCSrc),
        .wr_pc   (fetch_pc),
        .wr_inst (i_imem_data),
        .rd_pc   (o_inst_pc),
        .rd_inst (o_inst),
        .count   (count)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: two instances (RESET_PC 0x100 and 0x3FFF_FFFF) on
// shared stimulus, a per-instance behavioural model, and literal spot checks.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcsrc;
    logic [29:0] tgt;
    logic        ack_en;
    logic        ready;
    logic        ovr_en;
    logic [31:0] ovr;

    logic [1:0]        req, ack, vld;
    logic [1:0][31:0]  addr, data, inst;
    logic [1:0][29:0]  ipc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [29:0] w);
        return {2'b11, w} ^ 32'h0F0F_0F0F;
    endfunction

    // Simple memory responder: acks whenever enabled and a request is up.
    for (genvar k = 0; k < 2; k++) begin : g_mem
        assign ack[k]  = ack_en & req[k];
        assign data[k] = ovr_en ? ovr : inst_of(addr[k][31:2]);
    end

    fetch_pc_unit #(.RESET_PC(30'h100), .BUF_DEPTH(2)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_PCSrc(pcsrc), .i_PC_target(tgt),
        .o_imem_req(req[0]), .o_imem_addr(addr[0]), .i_imem_ack(ack[0]),
        .i_imem_data(data[0]), .o_inst_valid(vld[0]), .o_inst(inst[0]),
        .o_inst_pc(ipc[0]), .i_inst_ready(ready)
    );

    fetch_pc_unit #(.RESET_PC(30'h3FFF_FFFF), .BUF_DEPTH(2)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_PCSrc(pcsrc), .i_PC_target(tgt),
        .o_imem_req(req[1]), .o_imem_addr(addr[1]), .i_imem_ack(ack[1]),
        .i_imem_data(data[1]), .o_inst_valid(vld[1]), .o_inst(inst[1]),
        .o_inst_pc(ipc[1]), .i_inst_ready(ready)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [29:0] m_rst_pc [2];
    bit          m_req    [2];
    bit          m_keep   [2];
    logic [29:0] m_addr   [2];
    logic [29:0] m_pc     [2];
    logic [61:0] m_buf    [2][4];
    int          m_cnt    [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_req[k]  = 1'b0;
            m_keep[k] = 1'b1;
            m_addr[k] = m_rst_pc[k];
            m_pc[k]   = m_rst_pc[k];
            m_cnt[k]  = 0;
        end
    endtask

    task automatic model_step(input int k);
        bit          a, pu, po;
        logic [29:0] npc;
        logic [31:0] d;
        a   = ack_en && m_req[k];
        d   = ovr_en ? ovr : inst_of(m_addr[k]);
        po  = (m_cnt[k] != 0) && ready;
        pu  = a && m_keep[k] && !pcsrc;
        npc = pcsrc ? tgt : (pu ? m_pc[k] + 30'd1 : m_pc[k]);
        if (pcsrc) m_cnt[k] = 0;
        else begin
            if (po) begin
                for (int i = 0; i < 3; i++) m_buf[k][i] = m_buf[k][i+1];
                m_cnt[k]--;
            end
            if (pu) begin
                m_buf[k][m_cnt[k]] = {m_addr[k], d};
                m_cnt[k]++;
            end
        end
        m_pc[k] = npc;
        if (!m_req[k] || a) begin
            m_req[k]  = (m_cnt[k] < 2);
            m_keep[k] = 1'b1;
            m_addr[k] = npc;
        end else if (pcsrc) begin
            m_keep[k] = 1'b0;
        end
    endtask

    initial begin
        m_rst_pc[0] = 30'h100;
        m_rst_pc[1] = 30'h3FFF_FFFF;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m_req%0d", k), 64'(req[k]), 64'(m_req[k]));
                chk($sformatf("m_addr%0d", k), 64'(addr[k]), 64'({m_addr[k], 2'b00}));
                chk($sformatf("m_vld%0d", k), 64'(vld[k]), 64'(m_cnt[k] != 0));
                if (m_cnt[k] != 0) begin
                    chk($sformatf("m_inst%0d", k), 64'(inst[k]), 64'(m_buf[k][0][31:0]));
                    chk($sformatf("m_pc%0d", k), 64'(ipc[k]), 64'(m_buf[k][0][61:32]));
                end
            end
            if (rst_n) begin
                model_step(0);
                model_step(1);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step(1);
        rst_n = 1'b0; pcsrc = 1'b0; ack_en = 1'b0; ready = 1'b0; ovr_en = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; pcsrc = 1'b0; tgt = '0; ack_en = 1'b0; ready = 1'b0;
        ovr_en = 1'b0; ovr = 32'hDEAD_BEEF;
        step(3);
        chk("rst_req0", 64'(req[0]), 64'h0);
        chk("rst_addr0", 64'(addr[0]), 64'h400);
        chk("rst_addr1", 64'(addr[1]), 64'hFFFF_FFFC);
        chk("rst_vld0", 64'(vld[0]), 64'h0);
        chk("rst_inst0", 64'(inst[0]), 64'h0);
        chk("rst_ipc0", 64'(ipc[0]), 64'h0);

        // Streaming fetch, ack every cycle, decode always ready.
        rst_n = 1'b1; ack_en = 1'b1; ready = 1'b1;
        step(1);
        chk("t1_req", 64'(req[0]), 64'h1);
        chk("t1_addr0", 64'(addr[0]), 64'h400);
        chk("t1_addr1a", 64'(addr[1]), 64'hFFFF_FFFC);
        step(1);
        chk("t1_addr1", 64'(addr[0]), 64'h404);
        chk("t1_pc0", 64'(ipc[0]), 64'h100);
        chk("t1_inst0", 64'(inst[0]), 64'(inst_of(30'h100)));
        chk("t1_wrap_addr", 64'(addr[1]), 64'h0);
        chk("t1_wrap_pc", 64'(ipc[1]), 64'h3FFF_FFFF);
        step(1);
        chk("t1_addr2", 64'(addr[0]), 64'h408);
        chk("t1_pc1", 64'(ipc[0]), 64'h101);
        chk("t1_wrap_pc0", 64'(ipc[1]), 64'h0);
        step(1);
        chk("t1_pc2", 64'(ipc[0]), 64'h102);

        // Back-pressure: buffer fills after two pushes and fetch stops.
        do_reset();
        ack_en = 1'b1; ready = 1'b0;
        step(3);
        chk("t2_req_off", 64'(req[0]), 64'h0);
        chk("t2_addr_hold", 64'(addr[0]), 64'h408);
        step(1);
        chk("t2_addr_hold2", 64'(addr[0]), 64'h408);
        chk("t2_head", 64'(ipc[0]), 64'h100);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        chk("t2_req_on", 64'(req[0]), 64'h1);
        chk("t2_addr_on", 64'(addr[0]), 64'h408);
        step(1);
        chk("t2_req_off2", 64'(req[0]), 64'h0);

        // Redirect while waiting, ack arrives three cycles later.
        do_reset();
        ack_en = 1'b1; ready = 1'b0;
        step(2);
        chk("t3_buffered", 64'(vld[0]), 64'h1);
        ack_en = 1'b0; pcsrc = 1'b1; tgt = 30'h2000;
        step(1);
        pcsrc = 1'b0;
        chk("t3_flush", 64'(vld[0]), 64'h0);
        chk("t3_addr_old", 64'(addr[0]), 64'h404);
        step(2);
        chk("t3_addr_old2", 64'(addr[0]), 64'h404);
        chk("t3_req", 64'(req[0]), 64'h1);
        ack_en = 1'b1;
        step(1);
        chk("t3_addr_new", 64'(addr[0]), 64'h8000);
        chk("t3_dropped", 64'(vld[0]), 64'h0);
        ready = 1'b1;
        step(1);
        chk("t3_pc", 64'(ipc[0]), 64'h2000);

        // Redirect in the same cycle as the ack of 0xDEADBEEF.
        do_reset();
        ack_en = 1'b1; ready = 1'b1;
        step(2);
        pcsrc = 1'b1; tgt = 30'h40; ovr_en = 1'b1;
        step(1);
        pcsrc = 1'b0; ovr_en = 1'b0;
        chk("t4_vld", 64'(vld[0]), 64'h0);
        chk("t4_addr", 64'(addr[0]), 64'h100);
        step(1);
        chk("t4_pc", 64'(ipc[0]), 64'h40);
        chk("t4_inst", 64'(inst[0]), 64'(inst_of(30'h40)));

        // Two redirects while dropping: the newest target wins.
        do_reset();
        ack_en = 1'b0; ready = 1'b1;
        step(1);
        pcsrc = 1'b1; tgt = 30'h10;
        step(1);
        tgt = 30'h20;
        step(1);
        pcsrc = 1'b0; ack_en = 1'b1;
        chk("t5_addr_old", 64'(addr[0]), 64'h400);
        step(1);
        chk("t5_addr", 64'(addr[0]), 64'h80);
        step(1);
        chk("t5_pc", 64'(ipc[0]), 64'h20);
        chk("t5_addr2", 64'(addr[0]), 64'h84);

        // Asynchronous reset while a request is outstanding.
        ack_en = 1'b0;
        step(1);
        chk("t6_pre_req", 64'(req[0]), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_req", 64'(req[0]), 64'h0);
        chk("t6_addr", 64'(addr[0]), 64'h400);
        chk("t6_vld", 64'(vld[0]), 64'h0);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("t6_restart", 64'(req[0]), 64'h1);
        chk("t6_restart_addr", 64'(addr[0]), 64'h400);

        // Mixed pattern of stalls, back-pressure and redirects.
        for (int i = 0; i < 60; i++) begin
            ack_en = (i % 3) != 0;
            ready  = (i % 4) != 1;
            pcsrc  = (i % 11) == 5;
            tgt    = 30'(i * 7 + 30'h3FFF_FFF0);
            step(1);
        end
        pcsrc = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
